rf_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 2-read/1-write register file among `NUM_REQ` requesters (e.g. ALU writeback, load unit, CSR path). Each requester presents a valid/ready write request. One winner per cycle is granted, and its address and data are registered onto the register-file write port. The block sits directly in front of the register file's write port; read ports are untouched.

---
 rtl/rf_write_arbiter.sv | 85 ++++++++
 tb/tb_rf_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file write port; the winner's address/data are registered onto the port.
// Optional RF_WARB_ZERO_DISCARD_EN: accepted writes to register 0 are granted but never asserted on we_c_o.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
  input  logic                                 arb_hold_i,
  output logic [ADDR_WIDTH-1:0]                waddr_c_o,
  output logic [DATA_WIDTH-1:0]                wdata_c_o,
  output logic                                 we_c_o,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   scan_idx;
  logic            any_valid;
  logic            accept;
  logic            we_next;

  // Scan from the farthest offset down to ptr so the nearest valid requester is assigned last.
  always_comb begin
    any_valid = 1'b0;
    winner    = ptr_reg;
    scan_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (req_valid_i[scan_idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = scan_idx[ID_W-1:0];
      end
    end
  end

  // Ready is held low while in reset so nothing appears accepted during it.
  assign accept   = any_valid && !arb_hold_i && !rst;
  assign ptr_next = (winner == LAST_ID) ? '0 : winner + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = accept && (winner == ID_W'(gi));
    end
  endgenerate

`ifdef RF_WARB_ZERO_DISCARD_EN
  assign we_next = accept && (req_addr_i[winner] != '0);
`else
  assign we_next = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg    <= '0;
      we_c_o     <= 1'b0;
      waddr_c_o  <= '0;
      wdata_c_o  <= '0;
      grant_id_o <= '0;
    end else begin
      we_c_o <= we_next;
      if (accept) begin
        ptr_reg    <= ptr_next;
        waddr_c_o  <= req_addr_i[winner];
        wdata_c_o  <= req_data_i[winner];
        grant_id_o <= winner;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small register-file model on the write port.
module tb_rf_write_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid_i;
  logic [3:0]       req_ready_o;
  logic [3:0][4:0]  req_addr_i;
  logic [3:0][31:0] req_data_i;
  logic             arb_hold_i;
  logic [4:0]       waddr_c_o;
  logic [31:0]      wdata_c_o;
  logic             we_c_o;
  logic [1:0]       grant_id_o;

  int total;
  int passed;

`ifdef RF_WARB_ZERO_DISCARD_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  rf_write_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .arb_hold_i(arb_hold_i),
    .waddr_c_o(waddr_c_o), .wdata_c_o(wdata_c_o),
    .we_c_o(we_c_o), .grant_id_o(grant_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] rf [0:31];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we_c_o) begin
      rf[waddr_c_o] <= wdata_c_o;
    end
  end

  always @(negedge clk) begin
    if (!rst && we_c_o)
      $display("write r%0d <= %h (requester %0d)", waddr_c_o, wdata_c_o, grant_id_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_hold_i = 1'b0; req_valid_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      req_addr_i[k] = 5'(k + 1);
      req_data_i[k] = 32'hA0 + 32'(k);
    end
    tick(); tick();
    total++; if (req_ready_o !== 4'b0000) $display("FAIL rst_ready: got %b expected %b", req_ready_o, 4'b0000); else passed++;
    total++; if (we_c_o !== 1'b0) $display("FAIL rst_we: got %b expected %b", we_c_o, 1'b0); else passed++;
    total++; if (waddr_c_o !== 5'd0) $display("FAIL rst_waddr: got %h expected %h", waddr_c_o, 5'd0); else passed++;
    total++; if (wdata_c_o !== 32'd0) $display("FAIL rst_wdata: got %h expected %h", wdata_c_o, 32'd0); else passed++;
    total++; if (grant_id_o !== 2'd0) $display("FAIL rst_grant_id: got %0d expected %0d", grant_id_o, 0); else passed++;
    rst = 1'b0;
    #1;
    total++; if (req_ready_o !== 4'b0001) $display("FAIL rst_first_ready: got %b expected %b", req_ready_o, 4'b0001); else passed++;
    tick();
    total++; if (we_c_o !== 1'b1) $display("FAIL rst_first_we: got %b expected %b", we_c_o, 1'b1); else passed++;
    total++; if (wdata_c_o !== 32'hA0) $display("FAIL rst_first_wdata: got %h expected %h", wdata_c_o, 32'hA0); else passed++;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL rst_ptr_advanced: got %b expected %b", req_ready_o, 4'b0010); else passed++;
  endtask

  task automatic test_round_robin();
    int k;
    for (int c = 0; c < 8; c++) begin
      k = (c + 1) % 4;
      total++; if (req_ready_o !== 4'(1 << k)) $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready_o, 4'(1 << k)); else passed++;
      tick();
      total++; if (we_c_o !== 1'b1) $display("FAIL rr_we c=%0d: got %b expected %b", c, we_c_o, 1'b1); else passed++;
      total++; if (grant_id_o !== 2'(k)) $display("FAIL rr_grant c=%0d: got %0d expected %0d", c, grant_id_o, k); else passed++;
      total++; if (waddr_c_o !== 5'(k + 1)) $display("FAIL rr_waddr c=%0d: got %0d expected %0d", c, waddr_c_o, k + 1); else passed++;
      total++; if (wdata_c_o !== 32'hA0 + 32'(k)) $display("FAIL rr_wdata c=%0d: got %h expected %h", c, wdata_c_o, 32'hA0 + 32'(k)); else passed++;
      #1;
    end
    req_valid_i = 4'b0000;
    #1;
    total++; if (req_ready_o !== 4'b0000) $display("FAIL idle_ready: got %b expected %b", req_ready_o, 4'b0000); else passed++;
    tick();
    total++; if (we_c_o !== 1'b0) $display("FAIL idle_we: got %b expected %b", we_c_o, 1'b0); else passed++;
    total++; if (grant_id_o !== 2'd0) $display("FAIL idle_grant_hold: got %0d expected %0d", grant_id_o, 0); else passed++;
    total++; if (waddr_c_o !== 5'd1) $display("FAIL idle_waddr_hold: got %0d expected %0d", waddr_c_o, 1); else passed++;
    for (int r = 1; r <= 4; r++) begin
      total++; if (rf[r] !== 32'hA0 + 32'(r - 1)) $display("FAIL rr_readback r%0d: got %h expected %h", r, rf[r], 32'hA0 + 32'(r - 1)); else passed++;
    end
  endtask

  task automatic test_pointer_skip();
    req_valid_i = 4'b0010;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL skip_setup_ready: got %b expected %b", req_ready_o, 4'b0010); else passed++;
    tick();
    req_valid_i = 4'b1001;
    #1;
    total++; if (req_ready_o !== 4'b1000) $display("FAIL skip_ready_3: got %b expected %b", req_ready_o, 4'b1000); else passed++;
    tick();
    total++; if (grant_id_o !== 2'd3) $display("FAIL skip_grant_3: got %0d expected %0d", grant_id_o, 3); else passed++;
    req_valid_i = 4'b0001;
    #1;
    total++; if (req_ready_o !== 4'b0001) $display("FAIL skip_ready_0: got %b expected %b", req_ready_o, 4'b0001); else passed++;
    tick();
    total++; if (grant_id_o !== 2'd0) $display("FAIL skip_grant_0: got %0d expected %0d", grant_id_o, 0); else passed++;
    req_valid_i = 4'b0000;
  endtask

  task automatic test_hold();
    req_valid_i = 4'hF; arb_hold_i = 1'b1;
    req_addr_i[1] = 5'd7; req_data_i[1] = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready_o !== 4'b0000) $display("FAIL hold_ready c=%0d: got %b expected %b", c, req_ready_o, 4'b0000); else passed++;
      tick();
      total++; if (we_c_o !== 1'b0) $display("FAIL hold_we c=%0d: got %b expected %b", c, we_c_o, 1'b0); else passed++;
    end
    arb_hold_i = 1'b0;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL hold_release_ready: got %b expected %b", req_ready_o, 4'b0010); else passed++;
    tick();
    req_valid_i = 4'b0000;
    total++; if (we_c_o !== 1'b1) $display("FAIL hold_release_we: got %b expected %b", we_c_o, 1'b1); else passed++;
    total++; if (waddr_c_o !== 5'd7) $display("FAIL hold_release_waddr: got %0d expected %0d", waddr_c_o, 7); else passed++;
    tick();
    total++; if (rf[7] !== 32'hDEADBEEF) $display("FAIL hold_readback: got %h expected %h", rf[7], 32'hDEADBEEF); else passed++;
  endtask

  task automatic test_back_to_back();
    req_valid_i = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      req_addr_i[2] = 5'(10 + c);
      req_data_i[2] = 32'h100 + 32'(c);
      #1;
      total++; if (req_ready_o !== 4'b0100) $display("FAIL b2b_ready c=%0d: got %b expected %b", c, req_ready_o, 4'b0100); else passed++;
      tick();
      total++; if (we_c_o !== 1'b1) $display("FAIL b2b_we c=%0d: got %b expected %b", c, we_c_o, 1'b1); else passed++;
      total++; if (wdata_c_o !== 32'h100 + 32'(c)) $display("FAIL b2b_wdata c=%0d: got %h expected %h", c, wdata_c_o, 32'h100 + 32'(c)); else passed++;
    end
    req_valid_i = 4'b0000;
    tick();
    for (int c = 0; c < 4; c++) begin
      total++; if (rf[10 + c] !== 32'h100 + 32'(c)) $display("FAIL b2b_readback r%0d: got %h expected %h", 10 + c, rf[10 + c], 32'h100 + 32'(c)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    req_valid_i = 4'b1000;
    req_addr_i[3] = 5'd9; req_data_i[3] = 32'h55;
    #1;
    total++; if (req_ready_o !== 4'b1000) $display("FAIL rmid_ready: got %b expected %b", req_ready_o, 4'b1000); else passed++;
    tick();
    total++; if (we_c_o !== 1'b1) $display("FAIL rmid_we_before: got %b expected %b", we_c_o, 1'b1); else passed++;
    req_valid_i = 4'b0000;
    #2 rst = 1'b1;
    #1;
    total++; if (we_c_o !== 1'b0) $display("FAIL rmid_we_in_reset: got %b expected %b", we_c_o, 1'b0); else passed++;
    total++; if (waddr_c_o !== 5'd0) $display("FAIL rmid_waddr_in_reset: got %0d expected %0d", waddr_c_o, 0); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (we_c_o !== 1'b0) $display("FAIL rmid_we_after: got %b expected %b", we_c_o, 1'b0); else passed++;
    total++; if (rf[9] !== 32'h0) $display("FAIL rmid_write_lost: got %h expected %h", rf[9], 32'h0); else passed++;
  endtask

  task automatic test_zero_discard();
    req_valid_i = 4'b0001;
    req_addr_i[0] = 5'd0; req_data_i[0] = 32'h1234;
    #1;
    total++; if (req_ready_o !== 4'b0001) $display("FAIL zd_ready: got %b expected %b", req_ready_o, 4'b0001); else passed++;
    tick();
    req_valid_i = 4'b0000;
    total++; if (we_c_o !== !ZD) $display("FAIL zd_we: got %b expected %b", we_c_o, !ZD); else passed++;
    total++; if (grant_id_o !== 2'd0) $display("FAIL zd_grant: got %0d expected %0d", grant_id_o, 0); else passed++;
    tick();
    total++; if (rf[0] !== (ZD ? 32'h0 : 32'h1234)) $display("FAIL zd_readback: got %h expected %h", rf[0], ZD ? 32'h0 : 32'h1234); else passed++;
    req_valid_i = 4'hF;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL zd_ptr_advanced: got %b expected %b", req_ready_o, 4'b0010); else passed++;
    req_valid_i = 4'b0000;
    tick();
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; arb_hold_i = 1'b0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
    test_reset();
    test_round_robin();
    test_pointer_skip();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_zero_discard();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
